// File: rtl/dmem_req_issue_pkg.sv
// Shared definitions for the data-memory request issue block.
//   - size encodings for the 2-bit access-size field
//   - issue FSM state enum
//   - helpers: size -> byte-mask, alignment check
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RESP,
        ST_DRAIN
    } state_e;

    // Byte mask for an access of the given size, aligned to lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [2:0] off);
        logic r;
        case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = off[0];
            SZ_W:    r = |off[1:0];
            default: r = |off[2:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_req_issue_ld_data_align.sv
// Load data alignment / extension (purely combinational).
// Ports:
//   i_raw      raw 64-bit word returned by the data cache
//   i_off      byte offset of the access within the word
//   i_size     access size (SZ_B/H/W/D)
//   i_unsigned 1 = zero-extend, 0 = sign-extend
//   o_data     lane-0 justified, extended load value
module ld_data_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] i_raw,
    input  logic [2:0]        i_off,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_shifted;

    assign w_shifted = i_raw >> {i_off, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_size)
            SZ_B: o_data = {{(DATA_W-8){~i_unsigned & w_shifted[7]}},   w_shifted[7:0]};
            SZ_H: o_data = {{(DATA_W-16){~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            SZ_W: o_data = {{(DATA_W-32){~i_unsigned & w_shifted[31]}}, w_shifted[31:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/dmem_req_issue.sv
// Data-memory request issue stage between the ld/st sequencing FSM and the
// L1 data cache. Captures a request on mem_req_valid_i, checks alignment,
// drives a valid/ready request, tracks the single outstanding load and
// returns aligned/extended data. Kills are honoured in every phase; a load
// killed after its request was accepted is drained (its response dropped).
// Ports:
//   clk, rst                 clock, async active-high reset
//   mem_req_valid_i ...      request from the ld/st FSM (sampled on the pulse)
//   kill_mem_op_i            flush the current memory op
//   dcache_req_*             request channel to the L1 data cache
//   dcache_resp_*            load response from the L1 data cache
//   ld_resp_valid_o/data_o   registered load completion pulse + data
//   st_done_o                registered store-accepted pulse
//   misaligned_o             registered misaligned-access pulse
//   busy_o                   high whenever the FSM is not idle
module dmem_req_issue
    import dmem_pkg::*;
#(
    parameter int PADDR_W = 40,
    parameter int DATA_W  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_req_valid_i,
    input  logic               is_store_i,
    input  logic               kill_mem_op_i,
    input  logic [PADDR_W-1:0] paddr_i,
    input  logic [1:0]         size_i,
    input  logic               unsigned_i,
    input  logic [DATA_W-1:0]  st_data_i,
    output logic               dcache_req_valid_o,
    input  logic               dcache_req_ready_i,
    output logic               dcache_we_o,
    output logic [PADDR_W-1:0] dcache_addr_o,
    output logic [DATA_W-1:0]  dcache_wdata_o,
    output logic [7:0]         dcache_be_o,
    input  logic               dcache_resp_valid_i,
    input  logic [DATA_W-1:0]  dcache_resp_data_i,
    output logic               ld_resp_valid_o,
    output logic [DATA_W-1:0]  ld_resp_data_o,
    output logic               st_done_o,
    output logic               misaligned_o,
    output logic               busy_o
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [PADDR_W-1:0] r_addr;
    logic               r_we;
    logic [DATA_W-1:0]  r_wdata;
    logic [7:0]         r_be;
    logic [2:0]         r_off;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic               r_ld_valid;
    logic [DATA_W-1:0]  r_ld_data;
    logic               r_st_done;
    logic               r_misaligned;

    logic               w_capture;
    logic               w_ld_pulse;
    logic               w_st_pulse;
    logic               w_mis_pulse;
    logic               w_hs;
    logic [DATA_W-1:0]  w_ld_fmt;

    ld_data_align #(.DATA_W(DATA_W)) u_align (
        .i_raw      (dcache_resp_data_i),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_ld_fmt)
    );

    assign w_hs = (r_state == ST_ISSUE) && dcache_req_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_ld_pulse  = 1'b0;
        w_st_pulse  = 1'b0;
        w_mis_pulse = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_req_valid_i && !kill_mem_op_i) begin
                    if (is_misaligned(size_i, paddr_i[2:0])) begin
                        w_mis_pulse = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // A handshake wins over a kill: the request is already in the
                // cache, so a killed load must still consume its response.
                if (w_hs) begin
                    if (r_we) begin
                        w_st_pulse  = !kill_mem_op_i;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = kill_mem_op_i ? ST_DRAIN : ST_WAIT_RESP;
                    end
                end else if (kill_mem_op_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_RESP: begin
                if (dcache_resp_valid_i) begin
                    w_ld_pulse  = !kill_mem_op_i;
                    w_state_nxt = ST_IDLE;
                end else if (kill_mem_op_i) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dcache_resp_valid_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_ld_valid   <= 1'b0;
            r_ld_data    <= '0;
            r_st_done    <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ld_valid   <= w_ld_pulse;
            r_st_done    <= w_st_pulse;
            r_misaligned <= w_mis_pulse;
            if (w_capture) begin
                r_addr     <= {paddr_i[PADDR_W-1:3], 3'b000};
                r_we       <= is_store_i;
                r_wdata    <= st_data_i << {paddr_i[2:0], 3'b000};
                r_be       <= size_mask(size_i) << paddr_i[2:0];
                r_off      <= paddr_i[2:0];
                r_size     <= size_i;
                r_unsigned <= unsigned_i;
            end
            if (w_ld_pulse) begin
                r_ld_data <= w_ld_fmt;
            end
        end
    end

    // Request fields are zero outside ISSUE so nothing stale is presented.
    assign dcache_req_valid_o = (r_state == ST_ISSUE);
    assign dcache_we_o        = dcache_req_valid_o & r_we;
    assign dcache_addr_o      = dcache_req_valid_o ? r_addr  : '0;
    assign dcache_wdata_o     = dcache_req_valid_o ? r_wdata : '0;
    assign dcache_be_o        = dcache_req_valid_o ? r_be    : '0;
    assign ld_resp_valid_o    = r_ld_valid;
    assign ld_resp_data_o     = r_ld_data;
    assign st_done_o          = r_st_done;
    assign misaligned_o       = r_misaligned;
    assign busy_o             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_req_issue.sv
module tb_dmem_req_issue;
    import dmem_pkg::*;

    localparam int PADDR_W = 40;
    localparam int DATA_W  = 64;

    logic               clk;
    logic               rst;
    logic               mem_req_valid_i;
    logic               is_store_i;
    logic               kill_mem_op_i;
    logic [PADDR_W-1:0] paddr_i;
    logic [1:0]         size_i;
    logic               unsigned_i;
    logic [DATA_W-1:0]  st_data_i;
    logic               dcache_req_valid_o;
    logic               dcache_req_ready_i;
    logic               dcache_we_o;
    logic [PADDR_W-1:0] dcache_addr_o;
    logic [DATA_W-1:0]  dcache_wdata_o;
    logic [7:0]         dcache_be_o;
    logic               dcache_resp_valid_i;
    logic [DATA_W-1:0]  dcache_resp_data_i;
    logic               ld_resp_valid_o;
    logic [DATA_W-1:0]  ld_resp_data_o;
    logic               st_done_o;
    logic               misaligned_o;
    logic               busy_o;

    dmem_req_issue #(.PADDR_W(PADDR_W), .DATA_W(DATA_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_req_valid_i     (mem_req_valid_i),
        .is_store_i          (is_store_i),
        .kill_mem_op_i       (kill_mem_op_i),
        .paddr_i             (paddr_i),
        .size_i              (size_i),
        .unsigned_i          (unsigned_i),
        .st_data_i           (st_data_i),
        .dcache_req_valid_o  (dcache_req_valid_o),
        .dcache_req_ready_i  (dcache_req_ready_i),
        .dcache_we_o         (dcache_we_o),
        .dcache_addr_o       (dcache_addr_o),
        .dcache_wdata_o      (dcache_wdata_o),
        .dcache_be_o         (dcache_be_o),
        .dcache_resp_valid_i (dcache_resp_valid_i),
        .dcache_resp_data_i  (dcache_resp_data_i),
        .ld_resp_valid_o     (ld_resp_valid_o),
        .ld_resp_data_o      (ld_resp_data_o),
        .st_done_o           (st_done_o),
        .misaligned_o        (misaligned_o),
        .busy_o              (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_ld[$];
    int exp_st  = 0;
    int exp_mis = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are read there
    // or at the falling edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic st, input logic [PADDR_W-1:0] a, input logic [1:0] sz,
                         input logic uns, input logic [DATA_W-1:0] d);
        mem_req_valid_i = 1'b1;
        is_store_i      = st;
        paddr_i         = a;
        size_i          = sz;
        unsigned_i      = uns;
        st_data_i       = d;
        cyc();
        mem_req_valid_i = 1'b0;
    endtask

    // Scoreboard / pulse monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req_valid_i) chk("proto_req_only_when_idle", {63'b0, busy_o}, 64'd0);
            if (ld_resp_valid_o) begin
                if (exp_ld.size() == 0) chk("ld_resp_unexpected", {63'b0, ld_resp_valid_o}, 64'd0);
                else chk("ld_resp_data", ld_resp_data_o, exp_ld.pop_front());
            end
            if (st_done_o) begin
                chk("st_done_expected", {63'b0, st_done_o}, (exp_st > 0) ? 64'd1 : 64'd0);
                if (exp_st > 0) exp_st--;
            end
            if (misaligned_o) begin
                chk("misaligned_expected", {63'b0, misaligned_o}, (exp_mis > 0) ? 64'd1 : 64'd0);
                if (exp_mis > 0) exp_mis--;
            end
        end
    end

    initial begin
        rst                 = 1'b1;
        mem_req_valid_i     = 1'b0;
        is_store_i          = 1'b0;
        kill_mem_op_i       = 1'b0;
        paddr_i             = '0;
        size_i              = SZ_B;
        unsigned_i          = 1'b0;
        st_data_i           = '0;
        dcache_req_ready_i  = 1'b1;
        dcache_resp_valid_i = 1'b0;
        dcache_resp_data_i  = '0;
        cyc();
        cyc();
        chk("rst_req_valid", {63'b0, dcache_req_valid_o}, 64'd0);
        chk("rst_busy",      {63'b0, busy_o}, 64'd0);
        chk("rst_ld_valid",  {63'b0, ld_resp_valid_o}, 64'd0);
        chk("rst_ld_data",   ld_resp_data_o, 64'd0);
        chk("rst_st_done",   {63'b0, st_done_o}, 64'd0);
        chk("rst_misalign",  {63'b0, misaligned_o}, 64'd0);
        chk("rst_be",        {56'b0, dcache_be_o}, 64'd0);
        rst = 1'b0;
        cyc();

        // Load W signed at 0x1004, immediate ready.
        issue(1'b0, 40'h1004, SZ_W, 1'b0, '0);
        chk("t1_req_valid", {63'b0, dcache_req_valid_o}, 64'd1);
        chk("t1_addr",      {24'b0, dcache_addr_o}, 64'h1000);
        chk("t1_be",        {56'b0, dcache_be_o}, 64'hF0);
        chk("t1_we",        {63'b0, dcache_we_o}, 64'd0);
        chk("t1_busy",      {63'b0, busy_o}, 64'd1);
        cyc();
        chk("t1_req_dropped", {63'b0, dcache_req_valid_o}, 64'd0);
        chk("t1_busy_wait",   {63'b0, busy_o}, 64'd1);
        cyc();
        dcache_resp_valid_i = 1'b1;
        dcache_resp_data_i  = 64'h8000_0001_0000_0000;
        exp_ld.push_back(64'hFFFF_FFFF_8000_0001);
        cyc();
        dcache_resp_valid_i = 1'b0;
        chk("t1_ld_latency", {63'b0, ld_resp_valid_o}, 64'd1);
        chk("t1_idle",       {63'b0, busy_o}, 64'd0);
        cyc();
        chk("t1_ld_pulse_one", {63'b0, ld_resp_valid_o}, 64'd0);

        // Store H 0xBEEF at 0x2006 with ready held low 3 cycles.
        dcache_req_ready_i = 1'b0;
        issue(1'b1, 40'h2006, SZ_H, 1'b0, 64'hBEEF);
        for (int i = 0; i < 4; i++) begin
            chk("t2_req_valid", {63'b0, dcache_req_valid_o}, 64'd1);
            chk("t2_addr",      {24'b0, dcache_addr_o}, 64'h2000);
            chk("t2_be",        {56'b0, dcache_be_o}, 64'hC0);
            chk("t2_wdata",     dcache_wdata_o, 64'hBEEF_0000_0000_0000);
            chk("t2_we",        {63'b0, dcache_we_o}, 64'd1);
            chk("t2_no_early_done", {63'b0, st_done_o}, 64'd0);
            if (i == 3) begin
                dcache_req_ready_i = 1'b1;
                exp_st++;
            end
            cyc();
        end
        chk("t2_st_done",   {63'b0, st_done_o}, 64'd1);
        chk("t2_valid_off", {63'b0, dcache_req_valid_o}, 64'd0);
        chk("t2_idle",      {63'b0, busy_o}, 64'd0);
        cyc();
        chk("t2_st_done_one", {63'b0, st_done_o}, 64'd0);

        // Misaligned load D at 0x3004.
        exp_mis++;
        issue(1'b0, 40'h3004, SZ_D, 1'b0, '0);
        chk("t3_misaligned", {63'b0, misaligned_o}, 64'd1);
        chk("t3_no_req",     {63'b0, dcache_req_valid_o}, 64'd0);
        chk("t3_idle",       {63'b0, busy_o}, 64'd0);
        cyc();
        chk("t3_mis_one",    {63'b0, misaligned_o}, 64'd0);
        chk("t3_no_req2",    {63'b0, dcache_req_valid_o}, 64'd0);

        // Load killed in WAIT_RESP; response arrives 5 cycles later.
        issue(1'b0, 40'h4003, SZ_B, 1'b0, '0);
        cyc();
        kill_mem_op_i = 1'b1;
        cyc();
        kill_mem_op_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_busy", {63'b0, busy_o}, 64'd1);
            cyc();
        end
        dcache_resp_valid_i = 1'b1;
        dcache_resp_data_i  = 64'h1234_5678_9ABC_DEF0;
        chk("t4_busy_at_resp", {63'b0, busy_o}, 64'd1);
        cyc();
        dcache_resp_valid_i = 1'b0;
        chk("t4_idle_after", {63'b0, busy_o}, 64'd0);
        chk("t4_no_ld_pulse", {63'b0, ld_resp_valid_o}, 64'd0);
        // Follow-up loads: H unsigned, B signed.
        issue(1'b0, 40'h4006, SZ_H, 1'b1, '0);
        chk("t4_be_h", {56'b0, dcache_be_o}, 64'hC0);
        cyc();
        dcache_resp_valid_i = 1'b1;
        dcache_resp_data_i  = 64'h8123_0000_0000_0000;
        exp_ld.push_back(64'h0000_0000_0000_8123);
        cyc();
        dcache_resp_valid_i = 1'b0;
        chk("t4_ldh_valid", {63'b0, ld_resp_valid_o}, 64'd1);
        issue(1'b0, 40'h5003, SZ_B, 1'b0, '0);
        chk("t4_be_b", {56'b0, dcache_be_o}, 64'h08);
        cyc();
        dcache_resp_valid_i = 1'b1;
        dcache_resp_data_i  = 64'h0000_0000_9A00_0000;
        exp_ld.push_back(64'hFFFF_FFFF_FFFF_FF9A);
        cyc();
        dcache_resp_valid_i = 1'b0;
        chk("t4_ldb_valid", {63'b0, ld_resp_valid_o}, 64'd1);

        // Kill coincident with the request pulse.
        kill_mem_op_i = 1'b1;
        issue(1'b0, 40'h7000, SZ_D, 1'b0, '0);
        kill_mem_op_i = 1'b0;
        chk("t5a_no_req",  {63'b0, dcache_req_valid_o}, 64'd0);
        chk("t5a_idle",    {63'b0, busy_o}, 64'd0);
        chk("t5a_no_mis",  {63'b0, misaligned_o}, 64'd0);

        // Kill in ISSUE without handshake.
        dcache_req_ready_i = 1'b0;
        issue(1'b1, 40'h6000, SZ_D, 1'b0, 64'h1122_3344_5566_7788);
        chk("t5b_req_valid", {63'b0, dcache_req_valid_o}, 64'd1);
        chk("t5b_wdata",     dcache_wdata_o, 64'h1122_3344_5566_7788);
        chk("t5b_be",        {56'b0, dcache_be_o}, 64'hFF);
        kill_mem_op_i = 1'b1;
        cyc();
        kill_mem_op_i      = 1'b0;
        dcache_req_ready_i = 1'b1;
        chk("t5b_valid_drop", {63'b0, dcache_req_valid_o}, 64'd0);
        chk("t5b_idle",       {63'b0, busy_o}, 64'd0);
        cyc();
        chk("t5b_no_done", {63'b0, st_done_o}, 64'd0);

        // Kill coincident with a store handshake.
        issue(1'b1, 40'h6004, SZ_W, 1'b0, 64'h1234_5678);
        chk("t5c_be",    {56'b0, dcache_be_o}, 64'hF0);
        chk("t5c_wdata", dcache_wdata_o, 64'h1234_5678_0000_0000);
        kill_mem_op_i = 1'b1;
        cyc();
        kill_mem_op_i = 1'b0;
        chk("t5c_no_done", {63'b0, st_done_o}, 64'd0);
        chk("t5c_idle",    {63'b0, busy_o}, 64'd0);
        cyc();
        chk("t5c_no_done2", {63'b0, st_done_o}, 64'd0);

        // Kill coincident with a load handshake -> drain.
        issue(1'b0, 40'h7008, SZ_D, 1'b0, '0);
        kill_mem_op_i = 1'b1;
        cyc();
        kill_mem_op_i = 1'b0;
        chk("t5d_drain_busy", {63'b0, busy_o}, 64'd1);
        chk("t5d_no_req",     {63'b0, dcache_req_valid_o}, 64'd0);
        dcache_resp_valid_i = 1'b1;
        dcache_resp_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
        cyc();
        dcache_resp_valid_i = 1'b0;
        chk("t5d_idle",     {63'b0, busy_o}, 64'd0);
        chk("t5d_no_pulse", {63'b0, ld_resp_valid_o}, 64'd0);

        // Kill coincident with the response.
        issue(1'b0, 40'h7010, SZ_W, 1'b1, '0);
        cyc();
        dcache_resp_valid_i = 1'b1;
        kill_mem_op_i       = 1'b1;
        cyc();
        dcache_resp_valid_i = 1'b0;
        kill_mem_op_i       = 1'b0;
        chk("t5e_no_pulse", {63'b0, ld_resp_valid_o}, 64'd0);
        chk("t5e_idle",     {63'b0, busy_o}, 64'd0);

        // Asynchronous reset mid-cycle while in ISSUE.
        dcache_req_ready_i = 1'b0;
        issue(1'b0, 40'h8000, SZ_W, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6_req_valid", {63'b0, dcache_req_valid_o}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_valid", {63'b0, dcache_req_valid_o}, 64'd0);
        chk("t6_async_busy",  {63'b0, busy_o}, 64'd0);
        chk("t6_async_be",    {56'b0, dcache_be_o}, 64'd0);
        chk("t6_async_addr",  {24'b0, dcache_addr_o}, 64'd0);
        chk("t6_async_wdata", dcache_wdata_o, 64'd0);
        chk("t6_async_ldata", ld_resp_data_o, 64'd0);
        cyc();
        rst                = 1'b0;
        dcache_req_ready_i = 1'b1;
        dcache_resp_valid_i = 1'b1;
        dcache_resp_data_i  = 64'h0123_4567_89AB_CDEF;
        cyc();
        dcache_resp_valid_i = 1'b0;
        chk("t6_stray_resp", {63'b0, ld_resp_valid_o}, 64'd0);
        chk("t6_idle",       {63'b0, busy_o}, 64'd0);
        cyc();
        chk("t6_stray_resp2", {63'b0, ld_resp_valid_o}, 64'd0);

        cyc();
        chk("end_ld_pending",  64'(exp_ld.size()), 64'd0);
        chk("end_st_pending",  64'(exp_st), 64'd0);
        chk("end_mis_pending", 64'(exp_mis), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
